if_queue: RTL and testbench
===========================

IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of command slots (power of 2, 2..16).
REQ-002 SHALL have port clock, input, 1, single clock for all logic.
REQ-003 SHALL have port reset, input, 1; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port cmdq_select, input, 1, a valid CDB word is on cmd_in.
REQ-005 SHALL have port cmd_in, input, 32, CDB word.
REQ-006 SHALL have port queryin_select, input, 1, a query index is on querydata_inout.
REQ-007 SHALL have port queryout_select, output, 1, a query response is on querydata_inout.
REQ-008 SHALL have port querydata_inout, inout, 8, query index in / status out.
REQ-009 SHALL have port sq_select, output, 1, one-cycle dispatch strobe.
REQ-010 SHALL have port cmd_out, output, 256, dispatched CDB.
REQ-011 SHALL have port status_update_enable, input, 1, external completion strobe.
REQ-012 SHALL have port cmdq_index, input, 8, slot completed by status_update_enable.
REQ-013 SHALL have port xfer_buf_select, output, 1, transfer-buffer request.
REQ-014 SHALL have port mwrite_enable, output, 1, 1 = buffer-to-TBM, 0 = TBM-to-buffer.
REQ-015 SHALL have port tbm_address, output, 32, TBM block address.
REQ-016 SHALL have port xfer_complete, input, 1, one-cycle transfer-done pulse.

Function
REQ-017 SHALL capture cmd_in into word[n] of the CDB being assembled on each clock with cmdq_select=1, with n counting 0..7 and word0 in bits [31:0].
REQ-018 SHALL commit the CDB to the tail slot with status QUEUED (2'b01) on the 8th word, then advance the tail modulo DEPTH.
REQ-019 SHALL reset the word counter to 0, discarding the partial CDB, when cmdq_select=0 mid-CDB.
REQ-020 SHALL drop a complete CDB with no state change when all slots are non-FREE.
REQ-021 SHALL dispatch when the head slot is QUEUED and no transfer is active: sq_select=1 for one cycle, cmd_out=CDB, status to BUSY (2'b10).
REQ-022 SHALL decode the opcode from word0[7:0]: 0x40 is WRITE, 0x30 is READ, any other value is NONDATA.
REQ-023 SHALL, for WRITE or READ, assert xfer_buf_select from the cycle after sq_select until xfer_complete, with mwrite_enable=1 for WRITE and 0 for READ, and tbm_address=word1.
REQ-024 SHALL use word3[15:0] as the block count (0x0008 means 8x512 B = 1024 words); the count is carried in cmd_out only.
REQ-025 SHALL, on xfer_complete while busy, set the slot to DONE (2'b11), drop xfer_buf_select the same cycle and advance the head.
REQ-026 SHALL ignore xfer_complete when no transfer is active.
REQ-027 SHALL, for NONDATA, hold the slot BUSY until status_update_enable=1 with cmdq_index[log2 DEPTH-1:0] equal to that slot, then set it DONE and advance the head.
REQ-028 SHALL ignore status_update_enable when the indexed slot is not BUSY.
REQ-029 SHALL, on queryin_select=1, sample the index from querydata_inout[log2 DEPTH-1:0]; on the next cycle assert queryout_select for one cycle and drive querydata_inout = {4'b0, status[1:0], flags[1:0]}.
REQ-030 SHALL tri-state querydata_inout whenever queryout_select=0.
REQ-031 SHALL set a DONE slot to FREE in the cycle its DONE status is reported by a query.
REQ-032 SHALL, when a commit and a query free the same cycle, apply both; a commit targeting a slot freed that cycle is still dropped.

Reset
REQ-033 SHALL, with reset=0 at a clock edge, clear all slots to FREE, clear head, tail and word counter, drive every output low and tri-state querydata_inout.
REQ-034 SHALL, on reset mid-CDB or mid-transfer, abandon the operation with no completion.

Configuration
REQ-035 SHALL, with IF_QUEUE_STATUS_FLAGS_EN defined, report flags[1] = queue full and flags[0] = queue empty; without it, flags SHALL read 2'b00.

Structure
REQ-036 SHALL place status codes (FREE/QUEUED/BUSY/DONE), opcodes (0x40, 0x30), CDB_WORDS=8 and the DEPTH default in package if_queue_pkg.
REQ-037 SHALL implement CDB assembly (word counter + 256-bit shift register) as sub-module if_queue_cdb_asm.

Verification
REQ-038 SHALL cover: 8 words {0x40,0,0,0x01000008,0,0,0,0} -> sq_select pulse, cmd_out[31:0]=0x40, xfer_buf_select=1, mwrite_enable=1, tbm_address=0.
REQ-039 SHALL cover: xfer_complete pulse, then query index 0 -> queryout_select next cycle, querydata_inout[3:2]=2'b11; repeat query -> 2'b00.
REQ-040 SHALL cover: READ CDB (word0 = 0x30) -> mwrite_enable=0; query before completion -> [3:2]=2'b10.
REQ-041 SHALL cover: opcode 0x55 -> stays BUSY across xfer_complete; status_update_enable with cmdq_index=0 -> DONE.
REQ-042 SHALL cover: DEPTH+1 CDBs with no completion -> last dropped; flags=2'b10 when IF_QUEUE_STATUS_FLAGS_EN is defined.
REQ-043 SHALL cover: cmdq_select dropped after 4 words, then 8 fresh words -> exactly one commit holding the fresh words; reset mid-transfer -> xfer_buf_select=0, all slots FREE.

Source files
------------

// File: rtl/if_queue_pkg.sv
// Shared types and constants for the command queue and its CDB assembler.
package if_queue_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int CDB_WORDS     = 8;
  localparam int WORD_W        = 32;
  localparam int CDB_W         = CDB_WORDS * WORD_W;

  localparam logic [7:0] OPC_WRITE = 8'h40;
  localparam logic [7:0] OPC_READ  = 8'h30;

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_QUEUED = 2'b01,
    ST_BUSY   = 2'b10,
    ST_DONE   = 2'b11
  } slot_status_e;

  typedef enum logic [1:0] {
    OPK_NONDATA = 2'd0,
    OPK_WRITE   = 2'd1,
    OPK_READ    = 2'd2
  } op_kind_e;

  typedef enum logic [1:0] {
    ENG_IDLE     = 2'd0,
    ENG_DECODE   = 2'd1,
    ENG_XFER     = 2'd2,
    ENG_WAIT_STS = 2'd3
  } eng_state_e;

  function automatic op_kind_e decode_op(input logic [7:0] opc);
    if (opc == OPC_WRITE) return OPK_WRITE;
    if (opc == OPC_READ)  return OPK_READ;
    return OPK_NONDATA;
  endfunction

endpackage

// File: rtl/if_queue_cdb_asm.sv
// Collects eight consecutive 32-bit words into one 256-bit CDB; word0 lands in bits [31:0].
module if_queue_cdb_asm
  import if_queue_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              cdb_valid_o,
  output logic [CDB_W-1:0]  cdb_o
);

  localparam int CW = $clog2(CDB_WORDS);

  logic [CW-1:0]    cnt_q;
  logic [CDB_W-1:0] shreg_q;

  // The completed CDB is presented in the same cycle as its last word.
  assign cdb_o       = {word_i, shreg_q[CDB_W-1:WORD_W]};
  assign cdb_valid_o = word_valid_i && (cnt_q == CW'(CDB_WORDS - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (word_valid_i) begin
      cnt_q   <= cnt_q + CW'(1);
      shreg_q <= cdb_o;
    end else begin
      cnt_q   <= '0;
    end
  end

endmodule

// File: rtl/if_queue.sv
// Circular command queue with dispatch engine and status query port.
// Optional IF_QUEUE_STATUS_FLAGS_EN reports {full, empty} in the query response flags.
module if_queue
  import if_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmdq_select,
  input  logic [31:0]  cmd_in,
  input  logic         queryin_select,
  output logic         queryout_select,
  inout  wire  [7:0]   querydata_inout,
  output logic         sq_select,
  output logic [255:0] cmd_out,
  input  logic         status_update_enable,
  input  logic [7:0]   cmdq_index,
  output logic         xfer_buf_select,
  output logic         mwrite_enable,
  output logic [31:0]  tbm_address,
  input  logic         xfer_complete
);

  localparam int AW = $clog2(DEPTH);

  slot_status_e     status_q [DEPTH];
  logic [CDB_W-1:0] cdb_mem  [DEPTH];
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  eng_state_e       eng_q;

  logic             sq_select_q;
  logic [CDB_W-1:0] cmd_out_q;
  logic             xfer_buf_select_q;
  logic             mwrite_enable_q;
  logic [31:0]      tbm_address_q;
  logic             queryout_select_q;
  logic [7:0]       query_data_q;

  logic             cdb_valid;
  logic [CDB_W-1:0] cdb;
  logic             commit_en;
  logic [AW-1:0]    query_idx;
  logic [1:0]       flags;
  logic             unused_bits;

  if_queue_cdb_asm u_cdb_asm (
    .clock        (clock),
    .reset        (reset),
    .word_valid_i (cmdq_select),
    .word_i       (cmd_in),
    .cdb_valid_o  (cdb_valid),
    .cdb_o        (cdb)
  );

  // Slots are claimed in order, so the tail slot being taken means no room for the next CDB.
  assign commit_en   = cdb_valid && (status_q[tail_q] == ST_FREE);
  assign query_idx   = querydata_inout[AW-1:0];
  assign unused_bits = ^{cmdq_index[7:AW], querydata_inout[7:AW]};

`ifdef IF_QUEUE_STATUS_FLAGS_EN
  logic [DEPTH-1:0] free_vec;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_free
    assign free_vec[gi] = (status_q[gi] == ST_FREE);
  end
  assign flags = {status_q[tail_q] != ST_FREE, &free_vec};
`else
  assign flags = 2'b00;
`endif

  always_ff @(posedge clock) begin
    if (commit_en) begin
      cdb_mem[tail_q] <= cdb;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) status_q[i] <= ST_FREE;
      head_q            <= '0;
      tail_q            <= '0;
      eng_q             <= ENG_IDLE;
      sq_select_q       <= 1'b0;
      cmd_out_q         <= '0;
      xfer_buf_select_q <= 1'b0;
      mwrite_enable_q   <= 1'b0;
      tbm_address_q     <= '0;
      queryout_select_q <= 1'b0;
      query_data_q      <= '0;
    end else begin
      sq_select_q       <= 1'b0;
      queryout_select_q <= 1'b0;

      if (commit_en) begin
        status_q[tail_q] <= ST_QUEUED;
        tail_q           <= tail_q + AW'(1);
      end

      case (eng_q)
        ENG_IDLE: begin
          if (status_q[head_q] == ST_QUEUED) begin
            status_q[head_q] <= ST_BUSY;
            cmd_out_q        <= cdb_mem[head_q];
            sq_select_q      <= 1'b1;
            eng_q            <= ENG_DECODE;
          end
        end
        // The opcode is decoded from the registered cmd_out during the strobe cycle.
        ENG_DECODE: begin
          case (decode_op(cmd_out_q[7:0]))
            OPK_WRITE, OPK_READ: begin
              xfer_buf_select_q <= 1'b1;
              mwrite_enable_q   <= (decode_op(cmd_out_q[7:0]) == OPK_WRITE);
              tbm_address_q     <= cmd_out_q[63:32];
              eng_q             <= ENG_XFER;
            end
            default: eng_q <= ENG_WAIT_STS;
          endcase
        end
        ENG_XFER: begin
          if (xfer_complete) begin
            status_q[head_q]  <= ST_DONE;
            xfer_buf_select_q <= 1'b0;
            head_q            <= head_q + AW'(1);
            eng_q             <= ENG_IDLE;
          end
        end
        ENG_WAIT_STS: begin
          if (status_update_enable && (cmdq_index[AW-1:0] == head_q) &&
              (status_q[head_q] == ST_BUSY)) begin
            status_q[head_q] <= ST_DONE;
            head_q           <= head_q + AW'(1);
            eng_q            <= ENG_IDLE;
          end
        end
        default: eng_q <= ENG_IDLE;
      endcase

      // Reporting DONE hands the slot back to the pool.
      if (queryin_select) begin
        queryout_select_q <= 1'b1;
        query_data_q      <= {4'b0000, status_q[query_idx], flags};
        if (status_q[query_idx] == ST_DONE) status_q[query_idx] <= ST_FREE;
      end
    end
  end

  assign sq_select       = sq_select_q;
  assign cmd_out         = cmd_out_q;
  assign xfer_buf_select = xfer_buf_select_q;
  assign mwrite_enable   = mwrite_enable_q;
  assign tbm_address     = tbm_address_q;
  assign queryout_select = queryout_select_q;
  assign querydata_inout = queryout_select_q ? query_data_q : 8'hzz;

endmodule

// File: tb/tb_if_queue.sv
// Scoreboard bench for if_queue: stimulus queues expected dispatches, transfers and query replies.
module tb_if_queue;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmdq_select;
  logic [31:0]  cmd_in;
  logic         queryin_select;
  logic         queryout_select;
  wire  [7:0]   querydata_inout;
  logic         sq_select;
  logic [255:0] cmd_out;
  logic         status_update_enable;
  logic [7:0]   cmdq_index;
  logic         xfer_buf_select;
  logic         mwrite_enable;
  logic [31:0]  tbm_address;
  logic         xfer_complete;

  logic         q_drv_en;
  logic [7:0]   q_drv;
  assign querydata_inout = q_drv_en ? q_drv : 8'hzz;

  if_queue #(.DEPTH(8)) dut (
    .clock                (clock),
    .reset                (reset),
    .cmdq_select          (cmdq_select),
    .cmd_in               (cmd_in),
    .queryin_select       (queryin_select),
    .queryout_select      (queryout_select),
    .querydata_inout      (querydata_inout),
    .sq_select            (sq_select),
    .cmd_out              (cmd_out),
    .status_update_enable (status_update_enable),
    .cmdq_index           (cmdq_index),
    .xfer_buf_select      (xfer_buf_select),
    .mwrite_enable        (mwrite_enable),
    .tbm_address          (tbm_address),
    .xfer_complete        (xfer_complete)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [255:0] exp_sq   [$];
  logic [7:0]   exp_q    [$];
  logic [32:0]  exp_xfer [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] fl(input logic [1:0] f);
`ifdef IF_QUEUE_STATUS_FLAGS_EN
    return f;
`else
    return 2'b00;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  logic         xfer_prev = 1'b0;
  logic [255:0] m_sq;
  logic [7:0]   m_q;
  logic [32:0]  m_x;
  always @(negedge clock) begin
    if (reset) begin
      if (sq_select) begin
        if (exp_sq.size() == 0) check("sq_unexpected", 1, 0);
        else begin
          m_sq = exp_sq.pop_front();
          check("cmd_out", cmd_out, m_sq);
          $display("TXN dispatch opcode=%02h word1=%08h", cmd_out[7:0], cmd_out[63:32]);
        end
      end
      if (queryout_select) begin
        if (exp_q.size() == 0) check("query_unexpected", 1, 0);
        else begin
          m_q = exp_q.pop_front();
          check("query_data", querydata_inout, m_q);
          $display("TXN query data=%02h", querydata_inout);
        end
      end
      if (xfer_buf_select && !xfer_prev) begin
        if (exp_xfer.size() == 0) check("xfer_unexpected", 1, 0);
        else begin
          m_x = exp_xfer.pop_front();
          check("xfer_start", {mwrite_enable, tbm_address}, m_x);
          $display("TXN xfer mwrite=%0b addr=%08h", mwrite_enable, tbm_address);
        end
      end
    end
    xfer_prev = xfer_buf_select;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic send_cdb(input logic [255:0] c);
    for (int i = 0; i < 8; i++) begin
      cmdq_select = 1'b1;
      cmd_in      = c[32*i +: 32];
      tick();
    end
    cmdq_select = 1'b0;
    cmd_in      = '0;
  endtask

  task automatic query(input logic [7:0] idx, input logic [1:0] st, input logic [1:0] f);
    exp_q.push_back({4'b0000, st, fl(f)});
    q_drv_en       = 1'b1;
    q_drv          = idx;
    queryin_select = 1'b1;
    tick();
    q_drv_en       = 1'b0;
    queryin_select = 1'b0;
    tick();
  endtask

  task automatic pulse_complete();
    xfer_complete = 1'b1;
    tick();
    xfer_complete = 1'b0;
  endtask

  task automatic status_update(input logic [7:0] idx);
    status_update_enable = 1'b1;
    cmdq_index           = idx;
    tick();
    status_update_enable = 1'b0;
    cmdq_index           = '0;
  endtask

  logic [255:0] c;
  logic [255:0] t4 [9];

  initial begin
    reset = 1'b0; cmdq_select = 1'b0; cmd_in = '0; queryin_select = 1'b0;
    status_update_enable = 1'b0; cmdq_index = '0; xfer_complete = 1'b0;
    q_drv_en = 1'b0; q_drv = '0;
    do_reset();
    check("rst_sq_select", sq_select, 0);
    check("rst_cmd_out", cmd_out, 0);
    check("rst_xfer_buf", xfer_buf_select, 0);
    check("rst_mwrite", mwrite_enable, 0);
    check("rst_tbm", tbm_address, 0);
    check("rst_queryout", queryout_select, 0);

    // WRITE CDB, completion, then DONE report frees the slot
    c = {32'h0, 32'h0, 32'h0, 32'h0, 32'h01000008, 32'h0, 32'h0, 32'h00000040};
    exp_sq.push_back(c);
    exp_xfer.push_back({1'b1, 32'h0});
    send_cdb(c);
    tick(); tick(); tick();
    check("w_xfer_active", xfer_buf_select, 1);
    check("w_mwrite", mwrite_enable, 1);
    pulse_complete();
    check("w_xfer_dropped", xfer_buf_select, 0);
    query(8'd0, 2'b11, 2'b00);
    query(8'd0, 2'b00, 2'b01);

    // READ CDB, query while busy, then after completion
    do_reset();
    c = {32'h7, 32'h6, 32'h5, 32'h00000010, 32'h3, 32'h2, 32'h12345678, 32'h00000030};
    exp_sq.push_back(c);
    exp_xfer.push_back({1'b0, 32'h12345678});
    send_cdb(c);
    tick(); tick(); tick();
    check("r_mwrite", mwrite_enable, 0);
    query(8'd0, 2'b10, 2'b00);
    pulse_complete();
    query(8'd0, 2'b11, 2'b00);

    // NONDATA CDB waits for status_update_enable on its own slot
    do_reset();
    c = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF0000, 32'h00000055};
    exp_sq.push_back(c);
    send_cdb(c);
    tick(); tick(); tick();
    check("n_no_xfer", xfer_buf_select, 0);
    pulse_complete();
    query(8'd0, 2'b10, 2'b00);
    status_update(8'd1);
    query(8'd0, 2'b10, 2'b00);
    status_update(8'hF8);
    query(8'd0, 2'b11, 2'b00);
    query(8'd0, 2'b00, 2'b01);

    // DEPTH+1 CDBs with no completion: the last one is dropped
    do_reset();
    for (int k = 0; k < 9; k++) begin
      t4[k]          = '0;
      t4[k][7:0]     = 8'h10 + 8'(k);
      t4[k][255:224] = 32'hA0000000 + 32'(k);
    end
    exp_sq.push_back(t4[0]);
    for (int k = 0; k < 9; k++) send_cdb(t4[k]);
    tick(); tick();
    query(8'd0, 2'b10, 2'b10);
    query(8'd7, 2'b01, 2'b10);
    exp_sq.push_back(t4[1]);
    status_update(8'd0);
    tick(); tick();
    query(8'd0, 2'b11, 2'b10);
    query(8'd0, 2'b00, 2'b00);

    // Partial CDB abandoned, fresh CDB committed once, then reset mid-transfer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmdq_select = 1'b1;
      cmd_in      = (i == 0) ? 32'h40 : 32'hDEAD0000 + 32'(i);
      tick();
    end
    cmdq_select = 1'b0;
    tick();
    c = {32'h1007, 32'h1006, 32'h1005, 32'h00020004, 32'h1003, 32'h1002, 32'hCAFE0000, 32'h00000040};
    exp_sq.push_back(c);
    exp_xfer.push_back({1'b1, 32'hCAFE0000});
    send_cdb(c);
    tick(); tick(); tick();
    query(8'd1, 2'b00, 2'b00);
    query(8'd0, 2'b10, 2'b00);
    check("m_xfer_active", xfer_buf_select, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("m_rst_xfer", xfer_buf_select, 0);
    check("m_rst_cmd_out", cmd_out, 0);
    query(8'd0, 2'b00, 2'b01);
    query(8'd1, 2'b00, 2'b01);

    tick(); tick();
    check("left_sq", exp_sq.size(), 0);
    check("left_query", exp_q.size(), 0);
    check("left_xfer", exp_xfer.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
